// File: rtl/conv_weight_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_weight_sequencer_if
// Bundle between the layer controller (master) and the weight read sequencer
// (slave).
//   start/stall            : master -> sequencer (layer start, datapath stall)
//   busy/done              : sequencer status (busy level, one-cycle done)
//   addra/addrb/issue_v    : weight RAM read request (even/odd word pair)
//   rd_valid/acc_first/
//   acc_last/grp_idx       : tags aligned with the returning weight data
//   perf_cycles            : stall-cycle counter (zero when not built in)
// -----------------------------------------------------------------------------
interface conv_weight_sequencer_if #(
  parameter int WEIGHT_ADDR_WIDTH = 10,
  parameter int GRP_W             = 2
);
  logic                         start;
  logic                         stall;
  logic                         busy;
  logic                         done;
  logic [WEIGHT_ADDR_WIDTH-1:0] addra;
  logic [WEIGHT_ADDR_WIDTH-1:0] addrb;
  logic                         issue_v;
  logic                         rd_valid;
  logic                         acc_first;
  logic                         acc_last;
  logic [GRP_W-1:0]             grp_idx;
  logic [31:0]                  perf_cycles;

  modport master (
    output start, stall,
    input  busy, done, addra, addrb, issue_v, rd_valid,
           acc_first, acc_last, grp_idx, perf_cycles
  );

  modport slave (
    input  start, stall,
    output busy, done, addra, addrb, issue_v, rd_valid,
           acc_first, acc_last, grp_idx, perf_cycles
  );
endinterface

// File: rtl/conv_weight_sequencer.sv
// -----------------------------------------------------------------------------
// conv_weight_sequencer
// Walks the weight read schedule of one convolution layer: word pair within a
// pixel (beat), then output pixels, then output-map groups. Each issued beat
// reads two adjacent weight words; the issue tags (first/last beat of a pixel,
// group) travel through an RD_LATENCY-deep shift pipeline so they line up with
// the weight data leaving the RAM.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : conv_weight_sequencer_if.slave (start/stall in; busy, done,
//              addra, addrb, issue_v, rd_valid, acc_first, acc_last, grp_idx,
//              perf_cycles out). All outputs are registered.
//
// Optional feature: define SEQ_PERF_CNT_EN to build the stall-cycle counter
// behind perf_cycles; otherwise perf_cycles is tied to zero.
// -----------------------------------------------------------------------------
module conv_weight_sequencer #(
  parameter int NUM_ONE_PIXEL_CYCLE = 9,
  parameter int OUT_PIXELS          = 16,
  parameter int NUM_ONEMULT         = 4,
  parameter int WEIGHT_ADDR_WIDTH   = 10,
  parameter int RD_LATENCY          = 2,
  parameter int BEAT_W              = 4,
  parameter int PIX_W               = 4,
  parameter int GRP_W               = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  conv_weight_sequencer_if.slave  bus
);

  localparam int AW = WEIGHT_ADDR_WIDTH;

  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(NUM_ONE_PIXEL_CYCLE - 1);
  localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(OUT_PIXELS - 1);
  localparam logic [GRP_W-1:0]  GRP_MAX   = GRP_W'(NUM_ONEMULT - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0]  PIX_ONE   = {{(PIX_W-1){1'b0}}, 1'b1};
  localparam logic [GRP_W-1:0]  GRP_ONE   = {{(GRP_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]     ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]     BEAT_STRIDE = AW'(2);
  localparam logic [AW-1:0]     GRP_STRIDE  = AW'(2 * NUM_ONE_PIXEL_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [AW-1:0]      addra_q, addra_d;
  logic [AW-1:0]      addrb_q, addrb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Issue stage: tags registered together with the address
  logic               issue_v_q, issue_v_d;
  logic               tag_first_q, tag_first_d;
  logic               tag_last_q, tag_last_d;
  logic [GRP_W-1:0]   tag_grp_q, tag_grp_d;

  // Return pipeline; index RD_LATENCY-1 lines up with the RAM output
  logic [RD_LATENCY-1:0] pipe_v_q;
  logic [RD_LATENCY-1:0] pipe_first_q;
  logic [RD_LATENCY-1:0] pipe_last_q;
  logic [GRP_W-1:0]      pipe_grp_q [RD_LATENCY];

  logic [AW-1:0]      addr_s;
  logic               beat_end_s;
  logic               pix_end_s;
  logic               grp_end_s;
  logic               pipe_busy_s;

  // Address of the beat the counters currently point at (pixel index unused:
  // the same weights are re-read for every pixel of a group)
  always_comb begin
    addr_s     = (AW'(beat_q) * BEAT_STRIDE) + (AW'(grp_q) * GRP_STRIDE);
    beat_end_s = (beat_q == BEAT_MAX);
    pix_end_s  = (pix_q == PIX_MAX);
    grp_end_s  = (grp_q == GRP_MAX);
  end

  // Reads still in flight that will retire after the coming edge. The last
  // pipeline stage is excluded so DONE lands the cycle after the final
  // rd_valid.
  always_comb begin
    pipe_busy_s = issue_v_q;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      pipe_busy_s = pipe_busy_s | pipe_v_q[i];
    end
  end

  // FSM next state, schedule counters and issue-stage outputs
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pix_d       = pix_q;
    grp_d       = grp_q;
    addra_d     = addra_q;
    addrb_d     = addrb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_v_d   = 1'b0;
    tag_first_d = 1'b0;
    tag_last_d  = 1'b0;
    tag_grp_d   = {GRP_W{1'b0}};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          beat_d  = {BEAT_W{1'b0}};
          pix_d   = {PIX_W{1'b0}};
          grp_d   = {GRP_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (!bus.stall) begin
          issue_v_d   = 1'b1;
          addra_d     = addr_s;
          addrb_d     = addr_s + ADDR_ONE;
          tag_first_d = (beat_q == {BEAT_W{1'b0}});
          tag_last_d  = beat_end_s;
          tag_grp_d   = grp_q;
          if (beat_end_s) begin
            beat_d = {BEAT_W{1'b0}};
            if (pix_end_s) begin
              pix_d = {PIX_W{1'b0}};
              if (grp_end_s) begin
                grp_d   = {GRP_W{1'b0}};
                state_d = S_DRAIN;
              end else begin
                grp_d = grp_q + GRP_ONE;
              end
            end else begin
              pix_d = pix_q + PIX_ONE;
            end
          end else begin
            beat_d = beat_q + BEAT_ONE;
          end
        end else begin
          // Stalled: counters and addresses hold, nothing issued
          state_d = S_RUN;
        end
      end

      S_DRAIN: begin
        if (!pipe_busy_s) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, addresses and issue-stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      beat_q      <= {BEAT_W{1'b0}};
      pix_q       <= {PIX_W{1'b0}};
      grp_q       <= {GRP_W{1'b0}};
      addra_q     <= {AW{1'b0}};
      addrb_q     <= ADDR_ONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_v_q   <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_grp_q   <= {GRP_W{1'b0}};
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pix_q       <= pix_d;
      grp_q       <= grp_d;
      addra_q     <= addra_d;
      addrb_q     <= addrb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issue_v_q   <= issue_v_d;
      tag_first_q <= tag_first_d;
      tag_last_q  <= tag_last_d;
      tag_grp_q   <= tag_grp_d;
    end
  end

  // Valid/tag shift pipeline; keeps shifting through stalls so in-flight
  // reads retire
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v_q     <= {RD_LATENCY{1'b0}};
      pipe_first_q <= {RD_LATENCY{1'b0}};
      pipe_last_q  <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_grp_q[i] <= {GRP_W{1'b0}};
      end
    end else begin
      pipe_v_q[0]     <= issue_v_q;
      pipe_first_q[0] <= tag_first_q;
      pipe_last_q[0]  <= tag_last_q;
      pipe_grp_q[0]   <= tag_grp_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_q[i]     <= pipe_v_q[i-1];
        pipe_first_q[i] <= pipe_first_q[i-1];
        pipe_last_q[i]  <= pipe_last_q[i-1];
        pipe_grp_q[i]   <= pipe_grp_q[i-1];
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Stall-cycle counter: cleared on start acceptance, saturating, holds
  // after done until the next start
  always_comb begin
    if ((state_q == S_IDLE) && bus.start) begin
      perf_d = 32'd0;
    end else if ((state_q == S_RUN) && bus.stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Stall-cycle counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = 32'd0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.addra     = addra_q;
  assign bus.addrb     = addrb_q;
  assign bus.issue_v   = issue_v_q;
  assign bus.rd_valid  = pipe_v_q[RD_LATENCY-1];
  assign bus.acc_first = pipe_first_q[RD_LATENCY-1];
  assign bus.acc_last  = pipe_last_q[RD_LATENCY-1];
  assign bus.grp_idx   = pipe_grp_q[RD_LATENCY-1];

endmodule

// File: tb/tb_conv_weight_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_weight_sequencer
// Two sequencer instances: A (3 beats, 2 pixels, 2 groups, latency 2) and
// B (1/1/1, latency 1). A negedge monitor compares every issue and every
// returning read against expectations queued when the start is driven.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_weight_sequencer;

  localparam int WAW = 10;
  localparam int GW  = 2;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct {
    int             cyc;
    logic [WAW-1:0] addr;
    logic           first;
    logic           last;
    logic [GW-1:0]  grp;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start_r = 1'b0;
  logic stall_r = 1'b0;
  logic sel     = 1'b0;
  int   cyc     = 0;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   c_nb, c_op, c_ng, c_rd;

  exp_t iss_q[$];
  exp_t rd_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  conv_weight_sequencer_if #(.WEIGHT_ADDR_WIDTH(WAW), .GRP_W(GW)) ifa ();
  conv_weight_sequencer_if #(.WEIGHT_ADDR_WIDTH(WAW), .GRP_W(GW)) ifb ();

  assign ifa.start = start_r & ~sel;
  assign ifa.stall = stall_r & ~sel;
  assign ifb.start = start_r & sel;
  assign ifb.stall = stall_r & sel;

  conv_weight_sequencer #(
    .NUM_ONE_PIXEL_CYCLE(3), .OUT_PIXELS(2), .NUM_ONEMULT(2),
    .WEIGHT_ADDR_WIDTH(WAW), .RD_LATENCY(2), .BEAT_W(4), .PIX_W(4), .GRP_W(GW)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));

  conv_weight_sequencer #(
    .NUM_ONE_PIXEL_CYCLE(1), .OUT_PIXELS(1), .NUM_ONEMULT(1),
    .WEIGHT_ADDR_WIDTH(WAW), .RD_LATENCY(1), .BEAT_W(4), .PIX_W(4), .GRP_W(GW)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  logic           m_issue, m_rd, m_first, m_last, m_busy, m_done;
  logic [WAW-1:0] m_addra, m_addrb;
  logic [GW-1:0]  m_grp;
  logic [31:0]    m_perf;

  always_comb begin
    if (sel) begin
      m_issue = ifb.issue_v;  m_rd = ifb.rd_valid;  m_first = ifb.acc_first;
      m_last  = ifb.acc_last; m_busy = ifb.busy;    m_done  = ifb.done;
      m_addra = ifb.addra;    m_addrb = ifb.addrb;  m_grp   = ifb.grp_idx;
      m_perf  = ifb.perf_cycles;
    end else begin
      m_issue = ifa.issue_v;  m_rd = ifa.rd_valid;  m_first = ifa.acc_first;
      m_last  = ifa.acc_last; m_busy = ifa.busy;    m_done  = ifa.done;
      m_addra = ifa.addra;    m_addrb = ifa.addrb;  m_grp   = ifa.grp_idx;
      m_perf  = ifa.perf_cycles;
    end
  end

  // Scoreboard monitor: pop one expectation per issue and per returning read
  exp_t           mi;
  exp_t           mr;
  logic [WAW-1:0] mb;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (m_issue === 1'b1) begin
        chk_cnt++;
        if (iss_q.size() == 0) begin
          $display("FAIL issue_unexpected: cycle %0d addra %0d, want no issue", cyc, m_addra);
        end else begin
          mi = iss_q.pop_front();
          mb = mi.addr + 10'd1;
          if (cyc !== mi.cyc || m_addra !== mi.addr || m_addrb !== mb) begin
            $display("FAIL issue: got cycle %0d addra %0d addrb %0d, want cycle %0d addra %0d addrb %0d",
                     cyc, m_addra, m_addrb, mi.cyc, mi.addr, mb);
          end else begin
            pass_cnt++;
          end
        end
      end
      if (m_rd === 1'b1) begin
        chk_cnt++;
        if (rd_q.size() == 0) begin
          $display("FAIL rd_unexpected: cycle %0d, want no rd_valid", cyc);
        end else begin
          mr = rd_q.pop_front();
          if (cyc !== mr.cyc || m_first !== mr.first || m_last !== mr.last || m_grp !== mr.grp) begin
            $display("FAIL rd_tag: got cycle %0d first %b last %b grp %0d, want cycle %0d first %b last %b grp %0d",
                     cyc, m_first, m_last, m_grp, mr.cyc, mr.first, mr.last, mr.grp);
          end else begin
            pass_cnt++;
          end
        end
      end
    end
  end

  // One layer run: queue expectations, optionally stall / re-start / abort
  task automatic run_layer(input string name, input int stall_after, input int stall_len,
                           input int dup_at, input int abort_at);
    exp_t           e;
    int             n, e0, rel, exp_done, beat, grp;
    logic [WAW-1:0] hold_addr;
    bit             seen;
    @(negedge clk);
    chk_cnt++;
    if (m_done !== 1'b0) $display("FAIL %s done_width: done %b one cycle later, want 0", name, m_done);
    else pass_cnt++;
    start_r   = 1'b1;
    e0        = cyc + 1;
    n         = c_nb * c_op * c_ng;
    hold_addr = '0;
    for (int i = 0; i < n; i++) begin
      beat    = i % c_nb;
      grp     = i / (c_nb * c_op);
      e.cyc   = e0 + i + 1 + ((stall_len > 0 && (i + 1) > stall_after) ? stall_len : 0);
      e.addr  = WAW'(2 * beat + 2 * c_nb * grp);
      e.first = (beat == 0);
      e.last  = (beat == c_nb - 1);
      e.grp   = GW'(grp);
      if (i == stall_after - 1) hold_addr = e.addr;
      iss_q.push_back(e);
      e.cyc = e.cyc + c_rd;
      rd_q.push_back(e);
    end
    exp_done = e0 + n + c_rd + 1 + stall_len;
    @(negedge clk);
    start_r = 1'b0;
    chk_cnt++;
    if (m_busy !== 1'b1) $display("FAIL %s busy_on_start: got %b want 1", name, m_busy);
    else pass_cnt++;
    chk_cnt++;
    if (m_perf !== 32'd0) $display("FAIL %s perf_cleared: got %0d want 0", name, m_perf);
    else pass_cnt++;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      rel = cyc - e0;
      if (stall_len > 0 && rel == stall_after) stall_r = 1'b1;
      if (stall_len > 0 && rel == stall_after + stall_len) stall_r = 1'b0;
      if (stall_len > 0 && rel > stall_after && rel <= stall_after + stall_len) begin
        chk_cnt++;
        if (m_issue !== 1'b0 || m_addra !== hold_addr)
          $display("FAIL %s stall_hold: got issue_v %b addra %0d want 0 and %0d", name, m_issue, m_addra, hold_addr);
        else pass_cnt++;
      end
      if (dup_at > 0 && rel == dup_at) start_r = 1'b1;
      if (dup_at > 0 && rel == dup_at + 1) start_r = 1'b0;
      if (abort_at > 0 && rel == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (m_addra !== 10'd0 || m_addrb !== 10'd1 || m_busy !== 1'b0 || m_issue !== 1'b0 || m_rd !== 1'b0)
          $display("FAIL %s abort_state: got addra %0d addrb %0d busy %b issue_v %b rd_valid %b want 0 1 0 0 0",
                   name, m_addra, m_addrb, m_busy, m_issue, m_rd);
        else pass_cnt++;
        iss_q.delete();
        rd_q.delete();
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk_cnt++;
          if (m_done !== 1'b0 || m_busy !== 1'b0)
            $display("FAIL %s abort_no_done: got done %b busy %b want 0 0", name, m_done, m_busy);
          else pass_cnt++;
        end
        reset_n = 1'b1;
        return;
      end
      if (m_done === 1'b1) begin
        seen = 1'b1;
        chk_cnt++;
        if (cyc !== exp_done || m_busy !== 1'b0)
          $display("FAIL %s done_timing: got done at cycle %0d busy %b want cycle %0d busy 0", name, cyc, m_busy, exp_done);
        else pass_cnt++;
        chk_cnt++;
        if (m_perf !== (PERF_EN ? 32'(stall_len) : 32'd0))
          $display("FAIL %s perf_after_done: got %0d want %0d", name, m_perf, PERF_EN ? stall_len : 0);
        else pass_cnt++;
        chk_cnt++;
        if (iss_q.size() != 0 || rd_q.size() != 0)
          $display("FAIL %s missing_beats: got %0d issues %0d reads outstanding want 0 0", name, iss_q.size(), rd_q.size());
        else pass_cnt++;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL %s done_timeout: got no done want done at cycle %0d", name, exp_done);
      iss_q.delete();
      rd_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (ifa.addra !== 10'd0 || ifa.addrb !== 10'd1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 ||
        ifa.issue_v !== 1'b0 || ifa.rd_valid !== 1'b0 || ifa.acc_first !== 1'b0 ||
        ifa.acc_last !== 1'b0 || ifa.grp_idx !== 2'd0 || ifa.perf_cycles !== 32'd0)
      $display("FAIL reset_a: got addra %0d addrb %0d busy %b done %b issue_v %b rd_valid %b perf %0d want 0 1 0 0 0 0 0",
               ifa.addra, ifa.addrb, ifa.busy, ifa.done, ifa.issue_v, ifa.rd_valid, ifa.perf_cycles);
    else pass_cnt++;
    chk_cnt++;
    if (ifb.addra !== 10'd0 || ifb.addrb !== 10'd1 || ifb.busy !== 1'b0 || ifb.done !== 1'b0 ||
        ifb.issue_v !== 1'b0 || ifb.rd_valid !== 1'b0 || ifb.perf_cycles !== 32'd0)
      $display("FAIL reset_b: got addra %0d addrb %0d busy %b done %b issue_v %b rd_valid %b want 0 1 0 0 0 0",
               ifb.addra, ifb.addrb, ifb.busy, ifb.done, ifb.issue_v, ifb.rd_valid);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    sel = 1'b0; c_nb = 3; c_op = 2; c_ng = 2; c_rd = 2;
    run_layer("basic", 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    sel = 1'b0; c_nb = 3; c_op = 2; c_ng = 2; c_rd = 2;
    run_layer("stall", 5, 3, 0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; c_nb = 3; c_op = 2; c_ng = 2; c_rd = 2;
    run_layer("back_to_back", 0, 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    sel = 1'b0; c_nb = 3; c_op = 2; c_ng = 2; c_rd = 2;
    run_layer("start_ignored", 0, 0, 4, 0);
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b0; c_nb = 3; c_op = 2; c_ng = 2; c_rd = 2;
    run_layer("reset_abort", 0, 0, 0, 7);
    run_layer("reset_replay", 0, 0, 0, 0);
  endtask

  task automatic test_degenerate();
    sel = 1'b1; c_nb = 1; c_op = 1; c_ng = 1; c_rd = 1;
    run_layer("degenerate", 0, 0, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_degenerate();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/conv_weight_sequencer.md
# conv_weight_sequencer

Layer-level controller for one convolution engine's dual-port weight memory. Accepts a start request and walks the weight read schedule in a fixed order: word pair within an output pixel, then output pixels, then output-map groups computed by one multiplier. It drives both weight read addresses and tags each returning read with accumulator framing (first/last beat of a pixel). It honours a datapath stall and reports completion with a done pulse. It sits between the layer top-level FSM and the weight RAM plus MAC array.

## Interface
- NUM_ONE_PIXEL_CYCLE, 9: read beats per output pixel; each beat reads two weight words.
- OUT_PIXELS, 16: output pixels per map (OUT_FEATURE_WIDTH_W*OUT_FEATURE_WIDTH_H).
- NUM_ONEMULT, 4: output-map groups sequenced per layer.
- WEIGHT_ADDR_WIDTH, 10: weight RAM address width.
- RD_LATENCY, 2: cycles from address issue to weight data valid; must be ≥1.
- BEAT_W / PIX_W / GRP_W, 4 / 4 / 2: counter widths; each must hold its count minus 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  layer start request; sampled only in IDLE.
- stall  in  1  datapath not ready; freezes address issue.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- addra  out  WEIGHT_ADDR_WIDTH  port-A weight address (even word).
- addrb  out  WEIGHT_ADDR_WIDTH  port-B weight address (addra+1).
- issue_v  out  1  addra/addrb carry a real read this cycle.
- rd_valid  out  1  weight RAM output valid (issue_v delayed RD_LATENCY).
- acc_first  out  1  with rd_valid: first beat of a pixel (clear accumulator).
- acc_last  out  1  with rd_valid: last beat of a pixel (accumulator result valid).
- grp_idx  out  GRP_W  group of the beat currently on rd_valid.
- perf_cycles  out  32  stall-cycle count (see Configuration).

## Operation
- FSM: IDLE → RUN on start. RUN → DRAIN when the final beat issues. DRAIN → DONE when the valid pipeline is empty. DONE → IDLE after one cycle.
- Counters beat, pix and grp are cleared on entry to RUN.
- RUN with stall=0: issue one beat per cycle.
  - addra = 2*beat + 2*NUM_ONE_PIXEL_CYCLE*grp; addrb = addra+1; arithmetic is modulo 2^WEIGHT_ADDR_WIDTH.
  - beat wraps to 0 and increments pix; pix wraps to 0 and increments grp.
- Pixel index does not affect the address: weights are re-read for every pixel of a group.
- RUN with stall=1: counters and addresses hold; issue_v=0. The valid/tag shift pipeline keeps shifting, so in-flight reads still retire.
- stall is ignored in IDLE, DRAIN and DONE.
- acc_first/acc_last/grp_idx shift alongside issue_v and appear with the matching rd_valid.
- When NUM_ONE_PIXEL_CYCLE=1, acc_first and acc_last are both high on every beat.
- start while busy is ignored.
- Total issues per layer: N = NUM_ONE_PIXEL_CYCLE*OUT_PIXELS*NUM_ONEMULT.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, counters 0, addra=0, addrb=1, all other outputs 0 (perf_cycles included), shift pipeline cleared.
- Reset mid-layer aborts immediately; no done is produced.
- Start is sampled at edge E0 and busy goes high after E0.
- addra/addrb/issue_v are registered; the first issue is valid after E1.
- rd_valid for an issue at edge Ek is high after edge Ek+RD_LATENCY.
- With no stall, done is high for one cycle after edge E(N+RD_LATENCY+1); busy is low in that same cycle.
- Each stall cycle in RUN adds exactly one cycle to this figure.
- A new start is accepted the cycle after done.
- Simultaneous reset and start: reset wins.

## Configuration
- SEQ_PERF_CNT_EN defined: perf_cycles counts clk cycles with state RUN and stall=1. It is cleared on start acceptance and saturates at 2^32-1. It holds its value after done until the next start.
- SEQ_PERF_CNT_EN undefined: perf_cycles is tied to 0 and no counter logic is generated.

## Test plan
- Basic schedule (NUM_ONE_PIXEL_CYCLE=3, OUT_PIXELS=2, NUM_ONEMULT=2, RD_LATENCY=2), start pulse:
  - addra sequence is 0,2,4,0,2,4,6,8,10,6,8,10 on 12 consecutive issue_v cycles; addrb is always addra+1.
  - acc_first on rd_valid beats 1,4,7,10; acc_last on beats 3,6,9,12.
  - done after E15.
- Stall: same config with stall=1 for 3 cycles after the 5th issue:
  - addra holds at 2 and issue_v=0 during the stall.
  - Previously issued beats still appear on rd_valid.
  - done moves to after E18.
- Reset mid-run: reset_n low after the 7th issue:
  - Outputs return to addra=0, addrb=1, busy=0, no done.
  - A new start replays the full 12-beat sequence.
- Start ignored: start pulsed again while busy; sequence and done timing are unchanged. Back-to-back start the cycle after done is accepted.
- Degenerate case (NUM_ONE_PIXEL_CYCLE=1, OUT_PIXELS=1, NUM_ONEMULT=1, RD_LATENCY=1): single issue at addra=0; acc_first and acc_last both high; done after E3.
- SEQ_PERF_CNT_EN: the stall scenario gives perf_cycles=3 after done and 0 on the next start. Without the macro, perf_cycles stays 0.
